// File: rtl/mux_4to1_if.sv
// mux_4to1_if: data/select bundle for the 4:1 steering mux.
// master drives data and selects; slave (the mux) returns the selected
// value, its registered copy and the select-change pulse.
// sel_cnt exists only when MUX_4TO1_STATS_EN is defined.
interface mux_4to1_if #(
  parameter int WIDTH = 1
);
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] in3;
  logic             s0;
  logic             s1;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_q;
  logic             sel_chg;
`ifdef MUX_4TO1_STATS_EN
  logic [15:0]      sel_cnt;
`endif

  modport master (
    output in0, in1, in2, in3, s0, s1,
`ifdef MUX_4TO1_STATS_EN
    input  sel_cnt,
`endif
    input  out, out_q, sel_chg
  );

  modport slave (
    input  in0, in1, in2, in3, s0, s1,
`ifdef MUX_4TO1_STATS_EN
    output sel_cnt,
`endif
    output out, out_q, sel_chg
  );
endinterface

// File: rtl/mux_4to1.sv
// mux_4to1: 4:1 selector, sel = {s0,s1} with s0 as MSB.
// out is purely combinational; out_q / sel_chg form a registered shadow
// stage with asynchronous active-low reset.
// Optional feature macro: MUX_4TO1_STATS_EN adds a 16-bit saturating
// select-change counter on sel_cnt.
// WIDTH must match the WIDTH of the connected mux_4to1_if instance.
module mux_4to1 #(
  parameter int WIDTH = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mux_4to1_if.slave bus
);

  logic [1:0]       sel;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_r;
  logic [1:0]       sel_q;
  logic             chg_c;
  logic             chg_r;

  assign sel = {bus.s0, bus.s1};

  // Combinational select; unknown select codes fall to '0 so no latch forms
  always_comb begin
    out_c = '0;
    case (sel)
      2'b00:   out_c = bus.in0;
      2'b01:   out_c = bus.in1;
      2'b10:   out_c = bus.in2;
      2'b11:   out_c = bus.in3;
      default: out_c = '0;
    endcase
  end

  assign chg_c = (sel != sel_q);

  // Shadow stage: capture selected data, current select and change flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= '0;
      sel_q <= '0;
      chg_r <= 1'b0;
    end else begin
      out_r <= out_c;
      sel_q <= sel;
      chg_r <= chg_c;
    end
  end

`ifdef MUX_4TO1_STATS_EN
  logic [15:0] cnt_r;

  // Count on the same edge that raises sel_chg so sel_cnt equals pulses seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (chg_c && (cnt_r != '1)) begin
      cnt_r <= cnt_r + 16'd1;
    end
  end

  assign bus.sel_cnt = cnt_r;
`endif

  assign bus.out     = out_c;
  assign bus.out_q   = out_r;
  assign bus.sel_chg = chg_r;

endmodule

// File: tb/tb_mux_4to1.sv
// tb_mux_4to1: scoreboard bench for mux_4to1. Directed test-plan items
// push fixed expectations; randomized traffic pushes expectations from a
// behavioural model (array lookup for the mux, a previous-select variable
// and a clamped integer count for the registered stage). A monitor pops
// and compares on each observation event.
module tb_mux_4to1;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;

  mux_4to1_if #(.WIDTH(W)) bus();

  mux_4to1 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    bit           chk_out;
    logic [W-1:0] exp_out;
    bit           chk_reg;
    logic [W-1:0] exp_q;
    logic         exp_chg;
    bit           chk_cnt;
    int unsigned  exp_cnt;
  } exp_t;

  exp_t sb[$];
  event obs;
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- reference model ----------------
  logic [W-1:0] m_q;
  int unsigned  m_prev_sel;
  logic         m_chg;
  int unsigned  m_cnt;

  function automatic logic [W-1:0] ref_mux();
    logic [W-1:0] v[4];
    v[0] = bus.in0;
    v[1] = bus.in1;
    v[2] = bus.in2;
    v[3] = bus.in3;
    return v[int'({bus.s0, bus.s1})];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q        <= '0;
      m_prev_sel <= 0;
      m_chg      <= 1'b0;
      m_cnt      <= 0;
    end else begin
      m_q        <= ref_mux();
      m_prev_sel <= int'({bus.s0, bus.s1});
      m_chg      <= (int'({bus.s0, bus.s1}) != m_prev_sel);
      if (int'({bus.s0, bus.s1}) != m_prev_sel)
        m_cnt <= (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
    end
  end

  // ---------------- monitor ----------------
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(obs);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_out) chk({e.name, ".out"}, 32'(bus.out), 32'(e.exp_out));
        if (e.chk_reg) begin
          chk({e.name, ".out_q"},   32'(bus.out_q),   32'(e.exp_q));
          chk({e.name, ".sel_chg"}, 32'(bus.sel_chg), 32'(e.exp_chg));
        end
`ifdef MUX_4TO1_STATS_EN
        if (e.chk_cnt) chk({e.name, ".sel_cnt"}, 32'(bus.sel_cnt), 32'(e.exp_cnt));
`endif
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push(input exp_t e);
    sb.push_back(e);
    -> obs;
    #1;
  endtask

  task automatic expect_model(input string name);
    exp_t e;
    e.name    = name;
    e.chk_out = 1'b1;
    e.exp_out = ref_mux();
    e.chk_reg = 1'b1;
    e.exp_q   = m_q;
    e.exp_chg = m_chg;
    e.chk_cnt = 1'b1;
    e.exp_cnt = m_cnt;
    push(e);
  endtask

  task automatic expect_out(input string name, input logic [W-1:0] o);
    exp_t e;
    e.name    = name;
    e.chk_out = 1'b1;
    e.exp_out = o;
    e.chk_reg = 1'b0;
    e.exp_q   = '0;
    e.exp_chg = 1'b0;
    e.chk_cnt = 1'b0;
    e.exp_cnt = 0;
    push(e);
  endtask

  task automatic expect_reg(input string name, input logic [W-1:0] q, input logic c);
    exp_t e;
    e.name    = name;
    e.chk_out = 1'b0;
    e.exp_out = '0;
    e.chk_reg = 1'b1;
    e.exp_q   = q;
    e.exp_chg = c;
    e.chk_cnt = 1'b0;
    e.exp_cnt = 0;
    push(e);
  endtask

  task automatic expect_cnt(input string name, input int unsigned c);
    exp_t e;
    e.name    = name;
    e.chk_out = 1'b0;
    e.exp_out = '0;
    e.chk_reg = 1'b0;
    e.exp_q   = '0;
    e.exp_chg = 1'b0;
    e.chk_cnt = 1'b1;
    e.exp_cnt = c;
    push(e);
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d,
                       input logic [1:0] sel);
    bus.in0 = a;
    bus.in1 = b;
    bus.in2 = c;
    bus.in3 = d;
    bus.s0  = sel[1];
    bus.s1  = sel[0];
  endtask

  localparam logic [W-1:0] ONE = 1;
  localparam logic [W-1:0] ZRO = 0;

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    drive(ZRO, ZRO, ZRO, ZRO, 2'b00);
    #2;
    expect_reg("reset", ZRO, 1'b0);
`ifdef MUX_4TO1_STATS_EN
    expect_cnt("reset", 0);
`endif

    // one-hot selection, registered stage held in reset
    drive(ONE, ZRO, ZRO, ZRO, 2'b00); #10; expect_out("sel_a", ONE);
    drive(ZRO, ONE, ZRO, ZRO, 2'b01); #10; expect_out("sel_b", ONE);
    drive(ZRO, ZRO, ONE, ZRO, 2'b10); #10; expect_out("sel_c", ONE);
    drive(ZRO, ZRO, ZRO, ONE, 2'b11); #10; expect_out("sel_d", ONE);

    // cross-talk: selected input 0, others 1
    drive(ZRO, ONE, ONE, ONE, 2'b00); #10; expect_out("xt_00", ZRO);
    drive(ONE, ZRO, ONE, ONE, 2'b01); #10; expect_out("xt_01", ZRO);
    drive(ONE, ONE, ZRO, ONE, 2'b10); #10; expect_out("xt_10", ZRO);
    drive(ONE, ONE, ONE, ZRO, 2'b11); #10; expect_out("xt_11", ZRO);
    drive(ZRO, ZRO, ZRO, ZRO, 2'b11); #10; expect_out("all_zero", ZRO);

    // release with select 00: no pulse
    drive(ZRO, ZRO, ZRO, ZRO, 2'b00);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_reg("rel_00", ZRO, 1'b0);

    // registered path
    drive(ZRO, ZRO, ONE, ZRO, 2'b10);
    @(posedge clk); #1;
    expect_reg("reg_edge1", ONE, 1'b1);
    @(posedge clk); #1;
    expect_reg("reg_edge2", ONE, 1'b0);

    // asynchronous reset between edges
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    expect_reg("async_rst", ZRO, 1'b0);
    expect_out("async_out", ONE);
    bus.in2 = ZRO;
    #1;
    expect_out("async_track", ZRO);

    // release with select 11: one pulse
    drive(ZRO, ZRO, ZRO, 4'h9, 2'b11);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    expect_reg("rel_11", 4'h9, 1'b1);
    @(posedge clk); #1;
    expect_reg("rel_11_hold", 4'h9, 1'b0);

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (rst_n == 1'b0) rst_n = 1'b1;
      else if ($urandom_range(0, 39) == 0) rst_n = 1'b0;
      drive(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
            ($urandom_range(0, 2) == 0) ? {bus.s0, bus.s1} : 2'($urandom));
      expect_model("rand");
    end

`ifdef MUX_4TO1_STATS_EN
    // five changes after reset
    @(posedge clk); #1 rst_n = 1'b0;
    drive(ZRO, ZRO, ZRO, ZRO, 2'b00);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.s1 = ~bus.s1;
      @(posedge clk); #1;
    end
    expect_cnt("cnt_5", 5);
    expect_model("cnt_5_model");

    // saturation
    for (int i = 0; i < 70000; i++) begin
      bus.s1 = ~bus.s1;
      @(posedge clk); #1;
    end
    expect_cnt("cnt_sat", 32'hFFFF);
    bus.s1 = ~bus.s1;
    @(posedge clk); #1;
    expect_cnt("cnt_sat_hold", 32'hFFFF);
    expect_reg("cnt_sat_chg", ZRO, 1'b1);
`endif

    // drain the scoreboard with a bound
    for (int i = 0; i < 100 && sb.size() != 0; i++) #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
